kpn_scheduler: RTL and testbench

Firing controller for the KPN datapath: queue sources -> fifo1/fifo2 -> adder -> fifo3 -> subtractor -> BCD/display.
- Generates every actor strobe: queue wr, adder rd/wr, subtractor rd/wr, display load.
- Fires only on divided-clock ticks, and only when the actor's input FIFOs hold tokens and its output FIFO has room.
- Round-robin among eligible actors; one firing in flight at a time; optional token budget.

---
 rtl/kpn_pkg.sv | 25 ++
 rtl/kpn_rr_pick.sv | 26 ++
 rtl/kpn_scheduler.sv | 122 ++++++++++++
 tb/tb_kpn_scheduler.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/kpn_pkg.sv
// Shared FSM encodings, actor indices and the round-robin step helper
// for the KPN firing scheduler.
package kpn_pkg;

    typedef logic [2:0] kpn_state_t;

    localparam kpn_state_t ST_IDLE   = 3'd0;
    localparam kpn_state_t ST_SELECT = 3'd1;
    localparam kpn_state_t ST_SRC_WR = 3'd2;
    localparam kpn_state_t ST_ADD_RD = 3'd3;
    localparam kpn_state_t ST_ADD_WR = 3'd4;
    localparam kpn_state_t ST_SUB_RD = 3'd5;
    localparam kpn_state_t ST_SUB_WR = 3'd6;
    localparam kpn_state_t ST_DISP   = 3'd7;

    localparam logic [1:0] ACT_SRC = 2'd0;
    localparam logic [1:0] ACT_ADD = 2'd1;
    localparam logic [1:0] ACT_SUB = 2'd2;

    // Next actor in the fixed SRC -> ADD -> SUB -> SRC ring.
    function automatic logic [1:0] rr_next(input logic [1:0] a);
        return (a == ACT_SUB) ? ACT_SRC : a + 2'd1;
    endfunction

endpackage

// File: rtl/kpn_rr_pick.sv
// Combinational 3-way round-robin picker: first eligible actor at or after ptr.
module kpn_rr_pick
    import kpn_pkg::*;
(
    input  logic [2:0] eligible,
    input  logic [1:0] ptr,
    output logic [1:0] grant,
    output logic       valid
);

    logic [1:0] cand;

    always_comb begin
        grant = ptr;
        valid = 1'b0;
        cand  = ptr;
        for (int i = 0; i < 3; i++) begin
            if (!valid && eligible[cand]) begin
                grant = cand;
                valid = 1'b1;
            end
            cand = rr_next(cand);
        end
    end

endmodule

// File: rtl/kpn_scheduler.sv
// KPN actor firing controller. Define KPN_SCHED_STEP_EN to add a 'step'
// input that replaces 'tick' as the firing trigger for single-step debug.
module kpn_scheduler
    import kpn_pkg::*;
#(
    parameter int               CNT_W       = 16,
    parameter logic [CNT_W-1:0] TOKEN_LIMIT = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             tick,
`ifdef KPN_SCHED_STEP_EN
    input  logic             step,
`endif
    input  logic             fifo_1_full,
    input  logic             fifo_1_empty,
    input  logic             fifo_2_full,
    input  logic             fifo_2_empty,
    input  logic             fifo_3_full,
    input  logic             fifo_3_empty,
    output logic             queue_1_wr,
    output logic             queue_2_wr,
    output logic             adder_1_rd,
    output logic             adder_1_wr,
    output logic             subtractor_1_rd,
    output logic             subtractor_1_wr,
    output logic             display_load,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] tokens_out,
    output logic [2:0]       state_dbg
);

    // Every strobe is a registered single-cycle pulse; downstream FIFOs and
    // actors act on each high cycle exactly once, with no back-pressure.

    kpn_state_t state, next_state;
    logic [1:0] ptr;
    logic [1:0] grant;
    logic       pick_valid;
    logic [2:0] eligible;
    logic       limit_ok;
    logic       drained;
    logic       trig;

`ifdef KPN_SCHED_STEP_EN
    assign trig = step;
`else
    assign trig = tick;
`endif

    assign limit_ok = (TOKEN_LIMIT == '0) || (tokens_out < TOKEN_LIMIT);
    assign drained  = fifo_1_empty && fifo_2_empty && fifo_3_empty;

    assign eligible[ACT_SRC] = !fifo_1_full && !fifo_2_full && limit_ok;
    assign eligible[ACT_ADD] = !fifo_1_empty && !fifo_2_empty && !fifo_3_full;
    assign eligible[ACT_SUB] = !fifo_3_empty;

    kpn_rr_pick u_pick (
        .eligible (eligible),
        .ptr      (ptr),
        .grant    (grant),
        .valid    (pick_valid)
    );

    always_comb begin
        next_state = ST_IDLE;
        case (state)
            ST_IDLE:   next_state = (trig && start && !done) ? ST_SELECT : ST_IDLE;
            ST_SELECT: begin
                if (pick_valid) begin
                    case (grant)
                        ACT_SRC: next_state = ST_SRC_WR;
                        ACT_ADD: next_state = ST_ADD_RD;
                        default: next_state = ST_SUB_RD;
                    endcase
                end
            end
            ST_ADD_RD: next_state = ST_ADD_WR;
            ST_SUB_RD: next_state = ST_SUB_WR;
            ST_SUB_WR: next_state = ST_DISP;
            default:   next_state = ST_IDLE;
        endcase
    end

    // Strobes are decoded from next_state so they coincide with the state they name.
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= ST_IDLE;
            ptr             <= ACT_SRC;
            tokens_out      <= '0;
            done            <= 1'b0;
            queue_1_wr      <= 1'b0;
            queue_2_wr      <= 1'b0;
            adder_1_rd      <= 1'b0;
            adder_1_wr      <= 1'b0;
            subtractor_1_rd <= 1'b0;
            subtractor_1_wr <= 1'b0;
            display_load    <= 1'b0;
        end else begin
            state           <= next_state;
            queue_1_wr      <= (next_state == ST_SRC_WR);
            queue_2_wr      <= (next_state == ST_SRC_WR);
            adder_1_rd      <= (next_state == ST_ADD_RD);
            adder_1_wr      <= (next_state == ST_ADD_WR);
            subtractor_1_rd <= (next_state == ST_SUB_RD);
            subtractor_1_wr <= (next_state == ST_SUB_WR);
            display_load    <= (next_state == ST_DISP);
            if (state == ST_SELECT && pick_valid)
                ptr <= rr_next(grant);
            if (state == ST_SRC_WR && tokens_out != '1)
                tokens_out <= tokens_out + CNT_W'(1);
            if (state == ST_SELECT && TOKEN_LIMIT != '0 && tokens_out == TOKEN_LIMIT && drained)
                done <= 1'b1;
        end
    end

    assign busy      = (state != ST_IDLE);
    assign state_dbg = state;

endmodule

// File: tb/tb_kpn_scheduler.sv
// Directed bench for kpn_scheduler: one budgeted (TOKEN_LIMIT=2) and one
// unlimited instance driven by the same stimulus.
module tb_kpn_scheduler;
    import kpn_pkg::*;

    logic clk = 1'b0;
    logic reset, start, tick, cnt_clr;
    logic f1f, f1e, f2f, f2e, f3f, f3e;

    logic q1_l, q2_l, ar_l, aw_l, sr_l, sw_l, dl_l, busy_l, done_l;
    logic q1_i, q2_i, ar_i, aw_i, sr_i, sw_i, dl_i, busy_i, done_i;
    logic [15:0] tok_l, tok_i;
    logic [2:0]  st_l, st_i;
    logic [6:0]  sv_l, sv_i;

    int checks = 0;
    int errors = 0;
    int n_src_l, n_add_l, n_aw_l, n_sub_l, n_any_l, n_src_i;

    localparam logic [6:0] S_SRC = 7'h60;
    localparam logic [6:0] S_ARD = 7'h10;
    localparam logic [6:0] S_AWR = 7'h08;
    localparam logic [6:0] S_SRD = 7'h04;
    localparam logic [6:0] S_SWR = 7'h02;
    localparam logic [6:0] S_DSP = 7'h01;

    always #5 clk = ~clk;

    assign sv_l = {q1_l, q2_l, ar_l, aw_l, sr_l, sw_l, dl_l};
    assign sv_i = {q1_i, q2_i, ar_i, aw_i, sr_i, sw_i, dl_i};

    kpn_scheduler #(.CNT_W(16), .TOKEN_LIMIT(16'd2)) u_lim (
        .clk(clk), .reset(reset), .start(start), .tick(tick),
`ifdef KPN_SCHED_STEP_EN
        .step(tick),
`endif
        .fifo_1_full(f1f), .fifo_1_empty(f1e), .fifo_2_full(f2f), .fifo_2_empty(f2e),
        .fifo_3_full(f3f), .fifo_3_empty(f3e),
        .queue_1_wr(q1_l), .queue_2_wr(q2_l), .adder_1_rd(ar_l), .adder_1_wr(aw_l),
        .subtractor_1_rd(sr_l), .subtractor_1_wr(sw_l), .display_load(dl_l),
        .busy(busy_l), .done(done_l), .tokens_out(tok_l), .state_dbg(st_l)
    );

    kpn_scheduler #(.CNT_W(16), .TOKEN_LIMIT(16'd0)) u_inf (
        .clk(clk), .reset(reset), .start(start), .tick(tick),
`ifdef KPN_SCHED_STEP_EN
        .step(tick),
`endif
        .fifo_1_full(f1f), .fifo_1_empty(f1e), .fifo_2_full(f2f), .fifo_2_empty(f2e),
        .fifo_3_full(f3f), .fifo_3_empty(f3e),
        .queue_1_wr(q1_i), .queue_2_wr(q2_i), .adder_1_rd(ar_i), .adder_1_wr(aw_i),
        .subtractor_1_rd(sr_i), .subtractor_1_wr(sw_i), .display_load(dl_i),
        .busy(busy_i), .done(done_i), .tokens_out(tok_i), .state_dbg(st_i)
    );

    // Strobe pulse counters, sampled on the inactive edge.
    always @(negedge clk) begin
        if (cnt_clr) begin
            n_src_l <= 0; n_add_l <= 0; n_aw_l <= 0; n_sub_l <= 0; n_any_l <= 0; n_src_i <= 0;
        end else begin
            n_src_l <= n_src_l + int'(q1_l);
            n_add_l <= n_add_l + int'(ar_l);
            n_aw_l  <= n_aw_l + int'(aw_l);
            n_sub_l <= n_sub_l + int'(sr_l);
            n_any_l <= n_any_l + int'(sv_l != 7'h0);
            n_src_i <= n_src_i + int'(q1_i);
        end
    end

    task automatic step_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Tick high for one cycle; returns in the SELECT cycle.
    task automatic pulse_tick();
        tick = 1'b1;
        step_cyc();
        tick = 1'b0;
    endtask

    task automatic set_flags(input logic a_f, a_e, b_f, b_e, c_f, c_e);
        f1f = a_f; f1e = a_e; f2f = b_f; f2e = b_e; f3f = c_f; f3e = c_e;
    endtask

    task automatic clear_counts();
        cnt_clr = 1'b1;
        step_cyc();
        cnt_clr = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; tick = 1'b0; cnt_clr = 1'b1;
        set_flags(0, 1, 0, 1, 0, 1);
        step_cyc(); step_cyc();
        reset = 1'b0; cnt_clr = 1'b0;

        // reset state
        check("rst_strobes", sv_l, 7'h0);
        check("rst_busy", busy_l, 1'b0);
        check("rst_done", done_l, 1'b0);
        check("rst_tokens", tok_l, 16'd0);
        check("rst_state", st_l, ST_IDLE);

        // all FIFOs empty: SRC fires two cycles after the tick
        start = 1'b1;
        pulse_tick();
        check("src_select_state", st_l, ST_SELECT);
        check("src_select_busy", busy_l, 1'b1);
        check("src_select_nostrobe", sv_l, 7'h0);
        step_cyc();
        check("src_wr_strobe", sv_l, S_SRC);
        check("src_wr_strobe_inf", sv_i, S_SRC);
        step_cyc();
        check("src_back_idle", st_l, ST_IDLE);
        check("src_idle_strobes", sv_l, 7'h0);
        check("src_tokens", tok_l, 16'd1);

        // pointer at ADD; fifo1/2 hold data, fifo3 empty; a tick during ADD_RD is dropped
        set_flags(0, 0, 0, 0, 0, 1);
        pulse_tick();
        step_cyc();
        check("add_rd", sv_l, S_ARD);
        tick = 1'b1;
        step_cyc();
        tick = 1'b0;
        check("add_wr", sv_l, S_AWR);
        step_cyc();
        check("add_idle", st_l, ST_IDLE);
        step_cyc();
        check("add_tick_dropped", st_l, ST_IDLE);
        check("add_tick_dropped_strb", sv_l, 7'h0);

        // pointer at SUB; only fifo3 holds data
        set_flags(0, 1, 0, 1, 0, 0);
        pulse_tick();
        step_cyc();
        check("sub_rd", sv_l, S_SRD);
        step_cyc();
        check("sub_wr", sv_l, S_SWR);
        step_cyc();
        check("sub_disp", sv_l, S_DSP);
        check("sub_disp_busy", busy_l, 1'b1);
        step_cyc();
        check("sub_idle_busy", busy_l, 1'b0);

        // every actor eligible: pointer has wrapped back to SRC
        set_flags(0, 0, 0, 0, 0, 0);
        pulse_tick();
        step_cyc();
        check("ptr_wrap_src", sv_l, S_SRC);
        step_cyc();
        check("ptr_wrap_tokens", tok_l, 16'd2);

        // fifo1 full and fifo3 empty: only ADD is eligible
        set_flags(1, 0, 0, 0, 0, 1);
        pulse_tick();
        step_cyc();
        check("f1full_f3empty_add", sv_l, S_ARD);
        check("f1full_f3empty_add_inf", sv_i, S_ARD);
        step_cyc(); step_cyc();

        // fifo1 full and fifo3 full: only SUB may fire, twice in a row
        set_flags(1, 0, 0, 0, 1, 0);
        clear_counts();
        for (int k = 0; k < 2; k++) begin
            pulse_tick();
            step_cyc();
            check("full_sub_rd", sv_l, S_SRD);
            step_cyc(); step_cyc();
            check("full_sub_busy_hold", busy_l, 1'b1);
            step_cyc();
            check("full_sub_busy_drop", busy_l, 1'b0);
        end
        step_cyc();
        check("full_sub_count", n_sub_l, 2);
        check("full_src_count", n_src_l, 0);
        check("full_add_count", n_add_l, 0);

        // reset asserted during ADD_RD aborts the firing
        set_flags(1, 0, 0, 0, 0, 1);
        clear_counts();
        pulse_tick();
        step_cyc();
        check("abort_add_rd", sv_l, S_ARD);
        reset = 1'b1;
        step_cyc();
        reset = 1'b0;
        check("abort_strobes", sv_l, 7'h0);
        check("abort_state", st_l, ST_IDLE);
        check("abort_busy", busy_l, 1'b0);
        check("abort_tokens", tok_l, 16'd0);
        check("abort_done", done_l, 1'b0);
        step_cyc(); step_cyc();
        check("abort_no_add_wr", n_aw_l, 0);

        // token budget: 5 ticks with empty FIFOs, budgeted instance stops at 2
        set_flags(0, 1, 0, 1, 0, 1);
        clear_counts();
        for (int k = 0; k < 5; k++) begin
            pulse_tick();
            step_cyc(); step_cyc(); step_cyc();
        end
        check("budget_src_count", n_src_l, 2);
        check("budget_tokens", tok_l, 16'd2);
        check("budget_done", done_l, 1'b1);
        check("unlim_src_count", n_src_i, 5);
        check("unlim_tokens", tok_i, 16'd5);
        check("unlim_done", done_i, 1'b0);

        clear_counts();
        pulse_tick();
        check("done_no_select", busy_l, 1'b0);
        step_cyc(); step_cyc(); step_cyc();
        check("done_no_strobes", n_any_l, 0);
        check("done_sticky", done_l, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
